// File: rtl/msrv32_pkg.sv
// msrv32_pkg: shared types and constants for the RV32I PC stage.
//   pc_src_t   : next-PC source select as driven by the control unit
//   pc_state_t : PC generator FSM states
//   PC_INC     : sequential fetch increment
package msrv32_pkg;

    typedef enum logic [1:0] {
        PC_BOOT = 2'b00,
        PC_EPC  = 2'b01,
        PC_TRAP = 2'b10,
        PC_NEXT = 2'b11
    } pc_src_t;

    typedef enum logic [1:0] {
        S_BOOT = 2'b00,
        S_RUN  = 2'b01,
        S_HOLD = 2'b10
    } pc_state_t;

    localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/msrv32_pc_redirect_buf.sv
// msrv32_pc_redirect_buf: one-entry buffer holding a redirect target that
// arrived while the instruction bus was stalled.
//   clk_in, rst_in      : clock, synchronous active-high reset (drops entry)
//   load_i              : capture data_i as a new pending redirect
//   trap_override_i     : replace the pending target with data_i (trap)
//   consume_i           : entry used this cycle; clear valid (wins over writes)
//   data_i              : target to capture
//   valid_o, data_o     : buffered entry
module msrv32_pc_redirect_buf (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        load_i,
    input  logic        trap_override_i,
    input  logic        consume_i,
    input  logic [31:0] data_i,
    output logic        valid_o,
    output logic [31:0] data_o
);

    logic        valid_q;
    logic [31:0] data_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= 1'b0;
            data_q  <= 32'd0;
        end else if (consume_i) begin
            valid_q <= 1'b0;
        end else if (load_i || trap_override_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/msrv32_pc_gen.sv
// msrv32_pc_gen: next-PC generator and PC stage register of the RV32I core.
// Selects boot / EPC / trap / branch target / PC+4, holds the PC across
// instruction-bus wait states and buffers one redirect seen during a stall.
// Optional: define MSRV32_PC_MISALIGN_CHK_EN to flag taken branch/jump
// targets that are not word aligned instead of silently aligning them.
//   clk_in, rst_in        : clock, synchronous active-high reset
//   pc_src_in             : 00 BOOT, 01 EPC, 10 TRAP, 11 NEXT
//   branch_taken_in       : with NEXT, take iadder_in instead of PC+4
//   iadder_in             : branch/jump target from the immediate adder
//   epc_in, trap_address_in : mret return address, trap vector
//   ahb_ready_in          : instruction bus ready (0 = stall)
//   pc_out, pc_plus_4_out : registered stage PC and its link value
//   i_addr_out            : combinational fetch address
//   misaligned_instr_out  : registered one-cycle misaligned-target flag
module msrv32_pc_gen
    import msrv32_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [1:0]  pc_src_in,
    input  logic        branch_taken_in,
    input  logic [31:0] iadder_in,
    input  logic [31:0] epc_in,
    input  logic [31:0] trap_address_in,
    input  logic        ahb_ready_in,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus_4_out,
    output logic [31:0] i_addr_out,
    output logic        misaligned_instr_out
);

    pc_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt, sel, hold_tgt, pc_plus_4;
    logic        redirect, mis_now;
    logic        buf_load, buf_trap, buf_consume, buf_valid;
    logic [31:0] buf_data;
    pc_src_t     src;

    assign src       = pc_src_t'(pc_src_in);
    assign pc_plus_4 = pc_q + PC_INC;

`ifdef MSRV32_PC_MISALIGN_CHK_EN
    // Only bit 0 is cleared (JALR); bit 1 set means a misaligned target,
    // which is reported instead of followed.
    assign tgt     = {iadder_in[31:1], 1'b0};
    assign mis_now = (state_q == S_RUN) && (src == PC_NEXT) && branch_taken_in && tgt[1];

    logic mis_q;
    always_ff @(posedge clk_in) begin
        if (rst_in) mis_q <= 1'b0;
        else        mis_q <= mis_now;
    end
    assign misaligned_instr_out = mis_q;
`else
    assign tgt                  = {iadder_in[31:2], 2'b00};
    assign mis_now              = 1'b0;
    assign misaligned_instr_out = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = &{1'b0, iadder_in[1:0]};

    always_comb begin
        sel = pc_plus_4;
        unique case (src)
            PC_BOOT: sel = BOOT_ADDR;
            PC_EPC:  sel = epc_in;
            PC_TRAP: sel = trap_address_in;
            PC_NEXT: sel = branch_taken_in ? tgt : pc_plus_4;
            default: sel = pc_plus_4;
        endcase
    end

    assign redirect = (src != PC_NEXT) || branch_taken_in;
    // A trap arriving while stalled takes priority over the buffered target.
    assign hold_tgt = (src == PC_TRAP) ? trap_address_in : buf_data;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        i_addr_out  = pc_q;
        buf_load    = 1'b0;
        buf_trap    = 1'b0;
        buf_consume = 1'b0;
        unique case (state_q)
            S_BOOT: begin
                i_addr_out = BOOT_ADDR;
                if (ahb_ready_in) state_d = S_RUN;
            end
            S_RUN: begin
                if (mis_now) begin
                    i_addr_out = pc_q;
                end else if (ahb_ready_in) begin
                    pc_d       = sel;
                    i_addr_out = sel;
                end else if (redirect) begin
                    buf_load = 1'b1;
                    state_d  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!buf_valid) begin
                    // Entry lost (cannot happen in normal flow): resume sequencing.
                    state_d = S_RUN;
                end else begin
                    i_addr_out = hold_tgt;
                    buf_trap   = (src == PC_TRAP);
                    if (ahb_ready_in) begin
                        pc_d        = hold_tgt;
                        buf_consume = 1'b1;
                        state_d     = S_RUN;
                    end
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_BOOT;
            pc_q    <= BOOT_ADDR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    msrv32_pc_redirect_buf u_rbuf (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .load_i          (buf_load),
        .trap_override_i (buf_trap),
        .consume_i       (buf_consume),
        .data_i          (buf_load ? sel : trap_address_in),
        .valid_o         (buf_valid),
        .data_o          (buf_data)
    );

    assign pc_out        = pc_q;
    assign pc_plus_4_out = pc_plus_4;

endmodule
